// File: rtl/icg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// icg_ctrl_pkg
// Shared definitions for the clock-gate enable controller.
//   icg_state_e : 2-bit FSM state (OFF=0, WAKE=1, ON=2, HOLD=3)
//   WAKE_CNT_W  : width needed to hold the wake settle count (WAKE_CYC <= 15)
//   max_w()     : elaboration-time helper to size the shared down counter
// ---------------------------------------------------------------------------
package icg_ctrl_pkg;

  localparam int WAKE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } icg_state_e;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/icg_down_cnt.sv
// ---------------------------------------------------------------------------
// icg_down_cnt
// Loadable down counter that saturates at zero.
//   CLK      : clock
//   RN       : asynchronous active-low reset (count clears to 0)
//   load     : load load_val on the next edge (wins over dec)
//   load_val : value to load
//   dec      : decrement on the next edge (ignored when count is 0)
//   is_zero  : count == 0
//   is_one   : count == 1
// ---------------------------------------------------------------------------
module icg_down_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_zero,
  output logic         is_one
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      // Never wraps: a stray dec at zero holds the count.
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_zero = (cnt_q == '0);
  assign is_one  = (cnt_q == W'(1));

endmodule

// File: rtl/icg_enable_ctrl.sv
// ---------------------------------------------------------------------------
// icg_enable_ctrl
// Drives the E pin of a test-enabled clock gate from client activity. A
// request wakes the gated domain, ack is raised after a fixed settle time,
// and the clock is kept running for a programmable idle hold-off before E
// drops. A request arriving during the hold-off is acknowledged at once
// because the clock never stopped.
//   CLK        : free-running ungated clock
//   RN         : asynchronous active-low reset
//   req        : four-phase wake request from the client
//   ack        : gated clock running and stable (only ever high in ON)
//   busy       : gated-domain activity, keeps clock on while high
//   force_on   : software override, keeps E high while set
//   idle_limit : idle hold-off in CLK cycles, sampled on HOLD entry
//   E          : registered enable to the clock gate
//   state      : current FSM state for observation
// WAKE_CYC must be in 1..15.
// ---------------------------------------------------------------------------
module icg_enable_ctrl
  import icg_ctrl_pkg::*;
#(
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              req,
  output logic              ack,
  input  logic              busy,
  input  logic              force_on,
  input  logic [IDLE_W-1:0] idle_limit,
  output logic              E,
  output logic [1:0]        state
);

  // One counter serves both the wake settle and the idle hold-off, since
  // the two phases are mutually exclusive.
  localparam int               CNT_W     = max_w(IDLE_W, WAKE_CNT_W);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);

  icg_state_e       state_q, state_d;
  logic             e_q, e_d;
  logic             ack_q, ack_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             cnt_one;
  logic             wake;

  assign wake = req | busy | force_on;

  icg_down_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .CLK      (CLK),
    .RN       (RN),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .is_zero  (cnt_zero),
    .is_one   (cnt_one)
  );

  always_comb begin
    state_d      = state_q;
    e_d          = e_q;
    ack_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = WAKE_LOAD;

    case (state_q)
      ST_OFF: begin
        e_d = 1'b0;
        if (wake) begin
          state_d      = ST_WAKE;
          e_d          = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = WAKE_LOAD;
        end
      end

      ST_WAKE: begin
        // The wake always completes, even if req dropped meanwhile; ack
        // then simply follows whatever req is at that edge.
        e_d = 1'b1;
        if (cnt_zero) begin
          state_d = ST_ON;
          ack_d   = req;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_ON: begin
        e_d = 1'b1;
        if (wake) begin
          ack_d = req;
        end else if (idle_limit == '0) begin
          state_d = ST_OFF;
          e_d     = 1'b0;
        end else begin
          state_d      = ST_HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(idle_limit);
        end
      end

      ST_HOLD: begin
        e_d = 1'b1;
        if (wake) begin
          // Clock is still running: no settle delay needed.
          state_d = ST_ON;
          ack_d   = req;
        end else if (cnt_one) begin
          state_d = ST_OFF;
          e_d     = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: begin
        state_d = ST_OFF;
        e_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_OFF;
      e_q     <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      ack_q   <= ack_d;
    end
  end

  assign E     = e_q;
  assign ack   = ack_q;
  assign state = state_q;

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icg_enable_ctrl
// Directed scenarios followed by randomized client/busy/force_on traffic,
// checked every cycle against a deadline-based reference model.
// ---------------------------------------------------------------------------
module tb_icg_enable_ctrl;

  localparam int IDLE_W   = 8;
  localparam int WAKE_CYC = 2;

  // Reference-model phases, numbered as the observable state output.
  localparam int P_OFF  = 0;
  localparam int P_WAKE = 1;
  localparam int P_ON   = 2;
  localparam int P_HOLD = 3;

  logic              CLK = 1'b0;
  logic              RN;
  logic              req;
  logic              ack;
  logic              busy;
  logic              force_on;
  logic [IDLE_W-1:0] idle_limit;
  logic              E;
  logic [1:0]        state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: absolute-time deadlines instead of counters.
  int m_phase;
  int m_e;
  int m_ack;
  int m_ready_at;  // edge at which a cold wake completes
  int m_off_at;    // edge at which an idle hold-off expires

  always #5 CLK = ~CLK;

  icg_enable_ctrl #(
    .IDLE_W   (IDLE_W),
    .WAKE_CYC (WAKE_CYC)
  ) dut (
    .CLK        (CLK),
    .RN         (RN),
    .req        (req),
    .ack        (ack),
    .busy       (busy),
    .force_on   (force_on),
    .idle_limit (idle_limit),
    .E          (E),
    .state      (state)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_OFF;
    m_e     = 0;
    m_ack   = 0;
  endfunction

  function automatic void model_edge();
    bit w;
    w = req | busy | force_on;
    case (m_phase)
      P_OFF: if (w) begin
        m_phase    = P_WAKE;
        m_e        = 1;
        m_ack      = 0;
        m_ready_at = cyc + WAKE_CYC;
      end
      P_WAKE: if (cyc == m_ready_at) begin
        m_phase = P_ON;
        m_ack   = int'(req);
      end
      P_ON: begin
        if (w) begin
          m_ack = int'(req);
        end else begin
          m_ack = 0;
          if (idle_limit == 0) begin
            m_phase = P_OFF;
            m_e     = 0;
          end else begin
            m_phase  = P_HOLD;
            m_off_at = cyc + int'(idle_limit);
          end
        end
      end
      default: begin
        if (w) begin
          m_phase = P_ON;
          m_ack   = int'(req);
        end else if (cyc == m_off_at) begin
          m_phase = P_OFF;
          m_e     = 0;
        end
      end
    endcase
  endfunction

  task automatic compare_all();
    check_val("E", 32'(E), 32'(m_e));
    check_val("ack", 32'(ack), 32'(m_ack));
    check_val("state", 32'(state), 32'(m_phase));
    if (ack) begin
      check_val("proto_ack_only_on", 32'(state), 32'(P_ON));
      check_val("proto_ack_implies_E", 32'(E), 32'd1);
    end
  endtask

  // Advance one edge; outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    cyc++;
    if (RN) model_edge();
    #1;
    compare_all();
  endtask

  // Pull RN low between edges, check the asynchronous effect, hold it over
  // one edge, and release it mid-cycle.
  task automatic async_reset();
    #3 RN = 1'b0;
    #1;
    model_reset();
    check_val("async_rst_E", 32'(E), 32'd0);
    check_val("async_rst_ack", 32'(ack), 32'd0);
    check_val("async_rst_state", 32'(state), 32'(P_OFF));
    tick();
    #2 RN = 1'b1;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 40 && !ack; i++) tick();
    check_val("wait_ack", 32'(ack), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RN = 1'b0; req = 1'b0; busy = 1'b0; force_on = 1'b0; idle_limit = 8'd4;
    model_reset();
    tick();
    check_val("rst_E", 32'(E), 32'd0);
    check_val("rst_state", 32'(state), 32'(P_OFF));
    tick();
    #3 RN = 1'b1;

    // Cold wake at edge 10, release at edge 20, idle_limit=4.
    while (cyc < 9) tick();
    req = 1'b1;
    tick();
    check_val("cold_E", 32'(E), 32'd1);
    check_val("cold_state_wake", 32'(state), 32'(P_WAKE));
    tick();
    check_val("cold_ack_early", 32'(ack), 32'd0);
    tick();
    check_val("cold_ack", 32'(ack), 32'd1);
    check_val("cold_state_on", 32'(state), 32'(P_ON));
    while (cyc < 19) tick();
    req = 1'b0;
    tick();
    check_val("rel_ack", 32'(ack), 32'd0);
    check_val("rel_state_hold", 32'(state), 32'(P_HOLD));
    repeat (3) tick();
    check_val("hold_E", 32'(E), 32'd1);
    tick();
    check_val("idle_E_off", 32'(E), 32'd0);
    check_val("idle_state_off", 32'(state), 32'(P_OFF));

    // Warm wake from HOLD.
    req = 1'b1;
    wait_ack();
    req = 1'b0;
    tick();
    tick();
    req = 1'b1;
    tick();
    check_val("warm_ack", 32'(ack), 32'd1);
    check_val("warm_state", 32'(state), 32'(P_ON));

    // idle_limit = 0: immediate off.
    idle_limit = 8'd0;
    req = 1'b0;
    tick();
    check_val("zero_idle_E", 32'(E), 32'd0);
    check_val("zero_idle_state", 32'(state), 32'(P_OFF));

    // busy alone wakes the clock but never acks.
    busy = 1'b1;
    tick();
    check_val("busy_E", 32'(E), 32'd1);
    repeat (5) tick();
    check_val("busy_ack", 32'(ack), 32'd0);
    check_val("busy_state", 32'(state), 32'(P_ON));
    busy = 1'b0;
    tick();

    // force_on keeps E high after req and busy drop.
    idle_limit = 8'd4;
    req = 1'b1; busy = 1'b1; force_on = 1'b1;
    wait_ack();
    req = 1'b0; busy = 1'b0;
    repeat (30) tick();
    check_val("force_E", 32'(E), 32'd1);
    force_on = 1'b0;
    repeat (6) tick();
    check_val("force_release_state", 32'(state), 32'(P_OFF));

    // Reset in the middle of WAKE.
    req = 1'b1;
    tick();
    check_val("pre_rst_state", 32'(state), 32'(P_WAKE));
    async_reset();
    req = 1'b0;
    repeat (3) tick();
    check_val("post_rst_off", 32'(state), 32'(P_OFF));

    // Randomized traffic obeying the four-phase handshake.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      if (!req && !ack && $urandom_range(0, 5) == 0) req = 1'b1;
      else if (req && ack && $urandom_range(0, 3) == 0) req = 1'b0;
      if ($urandom_range(0, 9) == 0) busy = ~busy;
      if (!force_on && $urandom_range(0, 199) == 0) force_on = 1'b1;
      else if (force_on && $urandom_range(0, 19) == 0) force_on = 1'b0;
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 5))
          0: idle_limit = 8'd0;
          1: idle_limit = 8'd1;
          2: idle_limit = 8'd2;
          3: idle_limit = 8'd3;
          4: idle_limit = 8'd5;
          default: idle_limit = 8'($urandom_range(0, 20));
        endcase
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
